// File: rtl/drv_switch_pkg.sv
// ============================================================================
// drv_switch_pkg : shared types and helpers for the switch-driver blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package drv_switch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      HOLD  = 2'd2
   } t_entry_state;

   localparam int BCD_W = 4;

   function automatic int f_cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/drv_switch_digit_entry_cnt_timeout.sv
// ============================================================================
// cnt_timeout : idle timer, pulses o_expire on the last of p_limit quiet cycles
// Rev 1.0
// ============================================================================
`default_nettype none

module cnt_timeout #(
   parameter int p_limit = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_restart,
   output logic o_expire
);

   localparam int CW = (p_limit > 1) ? $clog2(p_limit) : 1;
   localparam logic [CW-1:0] LAST = CW'(p_limit - 1);

   logic [CW-1:0] cnt_q;

   // The counter only lives while enabled; disabling it doubles as a restart.
   always_ff @(posedge i_clk) begin
      if (i_rst || !i_en || i_restart) begin
         cnt_q <= '0;
      end else if (cnt_q != LAST) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign o_expire = i_en & ~i_restart & (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/drv_switch_digit_entry.sv
// ============================================================================
// drv_switch_digit_entry : assembles debounced key digits into a BCD code
// Rev 1.0
// ============================================================================
`default_nettype none

module drv_switch_digit_entry
   import drv_switch_pkg::*;
#(
   parameter int p_digits  = 4,
   parameter int p_timeout = 50_000_000
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic [3:0]                       i_val,
   input  logic                             i_unknown,
   input  logic                             i_toggle,
   input  logic                             i_enter,
   input  logic                             i_clear,
   input  logic                             i_ready,
   output logic [4*p_digits-1:0]            o_code,
   output logic [$clog2(p_digits+1)-1:0]    o_count,
   output logic                             o_valid,
   output logic                             o_active,
   output logic                             o_overflow,
   output logic                             o_timeout
);

   localparam int CODE_W = BCD_W * p_digits;
   localparam int CNT_W  = f_cnt_w(p_digits);

   t_entry_state      state_q;
   logic [CODE_W-1:0] code_q;
   logic [CNT_W-1:0]  count_q;
   logic              valid_q;
   logic              active_q;
   logic              overflow_q;
   logic              timeout_q;

   logic              w_digit_evt;
   logic              w_room;
   logic              w_expire;
   logic [CODE_W-1:0] w_shift;

   // Releases arrive flagged unknown, so only fresh presses of 0..9 count.
   assign w_digit_evt = i_toggle & ~i_unknown & (i_val <= 4'd9);
   assign w_room      = (count_q < CNT_W'(p_digits));
   assign w_shift     = (code_q << BCD_W) | CODE_W'(i_val);

   generate
      if (p_timeout > 0) begin : g_timeout
         cnt_timeout #(
            .p_limit   (p_timeout)
         ) u_cnt_timeout (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_en      (state_q == ENTRY),
            .i_restart (w_digit_evt | i_clear),
            .o_expire  (w_expire)
         );
      end else begin : g_no_timeout
         assign w_expire = 1'b0;
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         code_q     <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         active_q   <= 1'b0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
         if (i_clear) begin
            state_q  <= IDLE;
            code_q   <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (w_digit_evt) begin
                     code_q   <= CODE_W'(i_val);
                     count_q  <= CNT_W'(1);
                     active_q <= 1'b1;
                     state_q  <= ENTRY;
                  end
               end
               ENTRY: begin
                  // The digit lands before a same-cycle enter commits the code.
                  if (w_digit_evt) begin
                     if (w_room) begin
                        code_q  <= w_shift;
                        count_q <= count_q + CNT_W'(1);
                     end else begin
                        overflow_q <= 1'b1;
                     end
                  end
                  if (i_enter) begin
                     state_q  <= HOLD;
                     valid_q  <= 1'b1;
                     active_q <= 1'b0;
                  end else if (w_expire) begin
                     state_q   <= IDLE;
                     code_q    <= '0;
                     count_q   <= '0;
                     active_q  <= 1'b0;
                     timeout_q <= 1'b1;
                  end
               end
               HOLD: begin
                  if (valid_q && i_ready) begin
                     state_q <= IDLE;
                     code_q  <= '0;
                     count_q <= '0;
                     valid_q <= 1'b0;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign o_code     = code_q;
   assign o_count    = count_q;
   assign o_valid    = valid_q;
   assign o_active   = active_q;
   assign o_overflow = overflow_q;
   assign o_timeout  = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_drv_switch_digit_entry.sv
// ============================================================================
// tb_drv_switch_digit_entry : directed vector bench for the digit-entry block
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_drv_switch_digit_entry;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  val = 4'd0;
   logic        unk = 1'b0;
   logic        tog = 1'b0;
   logic        ent = 1'b0;
   logic        clr = 1'b0;
   logic        rdy = 1'b0;
   logic [15:0] code;
   logic [2:0]  count;
   logic        valid;
   logic        active;
   logic        ovf;
   logic        tmo;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   drv_switch_digit_entry #(
      .p_digits   (4),
      .p_timeout  (16)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_val      (val),
      .i_unknown  (unk),
      .i_toggle   (tog),
      .i_enter    (ent),
      .i_clear    (clr),
      .i_ready    (rdy),
      .o_code     (code),
      .o_count    (count),
      .o_valid    (valid),
      .o_active   (active),
      .o_overflow (ovf),
      .o_timeout  (tmo)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  val;
      logic        unk;
      logic        tog;
      logic        ent;
      logic        clr;
      logic        rdy;
      logic [15:0] code;
      logic [2:0]  cnt;
      logic        vld;
      logic        act;
      logic        ovf;
      logic        tmo;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic [3:0] v, input logic u,
                               input logic t, input logic e, input logic c, input logic y,
                               input logic [15:0] xc, input logic [2:0] xn, input logic xv,
                               input logic xa, input logic xo, input logic xt);
      vec_t m;
      m.rst = r; m.val = v; m.unk = u; m.tog = t; m.ent = e; m.clr = c; m.rdy = y;
      m.code = xc; m.cnt = xn; m.vld = xv; m.act = xa; m.ovf = xo; m.tmo = xt;
      return m;
   endfunction

   // Drive one cycle of inputs, then compare all outputs just after the edge.
   task automatic apply(input vec_t v, input string name);
      logic [22:0] act_o;
      logic [22:0] exp_o;
      @(negedge clk);
      rst = v.rst; val = v.val; unk = v.unk; tog = v.tog;
      ent = v.ent; clr = v.clr; rdy = v.rdy;
      @(posedge clk);
      #1;
      act_o = {code, count, valid, active, ovf, tmo};
      exp_o = {v.code, v.cnt, v.vld, v.act, v.ovf, v.tmo};
      checks++;
      if (act_o !== exp_o) begin
         failures++;
         $display("FAIL %s: got code=%h cnt=%0d vld=%b act=%b ovf=%b tmo=%b, want code=%h cnt=%0d vld=%b act=%b ovf=%b tmo=%b",
                  name, code, count, valid, active, ovf, tmo,
                  v.code, v.cnt, v.vld, v.act, v.ovf, v.tmo);
      end
   endtask

   task automatic idle_steps(input int n, input logic [15:0] xc, input logic [2:0] xn,
                             input string name);
      for (int i = 0; i < n; i++) begin
         apply(mk(0, 0, 0, 0, 0, 0, 0, xc, xn, 0, 1, 0, 0), name);
      end
   endtask

   initial begin
      //           rst val unk tog ent clr rdy  code     cnt vld act ovf tmo
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0)); // reset
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 16'h0001, 1, 0, 1, 0, 0)); // basic
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0001, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 2, 0, 1, 0, 0, 0, 16'h0012, 2, 0, 1, 0, 0));
      tbl.push_back(mk(0, 2, 1, 1, 0, 0, 0, 16'h0012, 2, 0, 1, 0, 0)); // release
      tbl.push_back(mk(0, 3, 0, 1, 0, 0, 0, 16'h0123, 3, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 16'h0123, 3, 1, 0, 0, 0)); // commit
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0123, 3, 1, 0, 0, 0)); // hold
      tbl.push_back(mk(0, 5, 0, 1, 0, 0, 0, 16'h0123, 3, 1, 0, 0, 0)); // ignored
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0)); // handshake
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0)); // enter idle
      tbl.push_back(mk(0, 4, 1, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0)); // unknown
      tbl.push_back(mk(0, 12, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0)); // illegal C
      tbl.push_back(mk(0, 9, 0, 1, 0, 0, 0, 16'h0009, 1, 0, 1, 0, 0)); // overflow
      tbl.push_back(mk(0, 8, 0, 1, 0, 0, 0, 16'h0098, 2, 0, 1, 0, 0));
      tbl.push_back(mk(0, 7, 0, 1, 0, 0, 0, 16'h0987, 3, 0, 1, 0, 0));
      tbl.push_back(mk(0, 6, 0, 1, 0, 0, 0, 16'h9876, 4, 0, 1, 0, 0));
      tbl.push_back(mk(0, 5, 0, 1, 0, 0, 0, 16'h9876, 4, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h9876, 4, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 16'h9876, 4, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4, 0, 1, 0, 0, 0, 16'h0004, 1, 0, 1, 0, 0)); // simultaneous
      tbl.push_back(mk(0, 2, 0, 1, 0, 0, 0, 16'h0042, 2, 0, 1, 0, 0));
      tbl.push_back(mk(0, 7, 0, 1, 1, 0, 0, 16'h0427, 3, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 16'h0000, 0, 0, 0, 0, 0)); // clear+ready
      tbl.push_back(mk(0, 4, 0, 1, 0, 0, 0, 16'h0004, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 3, 0, 1, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 0)); // digit+clear
      tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 16'h0001, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 2, 0, 1, 0, 0, 0, 16'h0012, 2, 0, 1, 0, 0));
      tbl.push_back(mk(1, 3, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0)); // reset mid-entry
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 6, 0, 1, 0, 0, 0, 16'h0006, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 16'h0006, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0)); // reset in hold

      foreach (tbl[i]) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      // Timeout: press, 15 quiet cycles still active, 16th abandons entry.
      apply(mk(0, 5, 0, 1, 0, 0, 0, 16'h0005, 1, 0, 1, 0, 0), "to_press");
      idle_steps(15, 16'h0005, 1, "to_wait");
      apply(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1), "to_expire");
      apply(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0), "to_after");

      // A press at quiet cycle 10 restarts the 16-cycle window.
      apply(mk(0, 5, 0, 1, 0, 0, 0, 16'h0005, 1, 0, 1, 0, 0), "rs_press");
      idle_steps(9, 16'h0005, 1, "rs_wait1");
      apply(mk(0, 6, 0, 1, 0, 0, 0, 16'h0056, 2, 0, 1, 0, 0), "rs_press2");
      idle_steps(15, 16'h0056, 2, "rs_wait2");
      apply(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1), "rs_expire");

      // Enter on the terminal quiet cycle beats the timeout.
      apply(mk(0, 5, 0, 1, 0, 0, 0, 16'h0005, 1, 0, 1, 0, 0), "te_press");
      idle_steps(15, 16'h0005, 1, "te_wait");
      apply(mk(0, 0, 0, 0, 1, 0, 0, 16'h0005, 1, 1, 0, 0, 0), "te_enter");
      apply(mk(0, 0, 0, 0, 0, 0, 0, 16'h0005, 1, 1, 0, 0, 0), "te_hold");
      apply(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0), "te_ready");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
